// File: rtl/dmac_wb_regs_param_pkg.sv
// Shared definitions for the DMAC register slave: register word addresses,
// CHCR/ICR bit positions, the slave-control state type and lane-mask helpers.
package dmac_wb_regs_param_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } ctrl_state_e;

  // Channel register word offsets within a 16-byte channel block.
  localparam logic [1:0] OFF_MADR = 2'd0;
  localparam logic [1:0] OFF_BCR  = 2'd1;
  localparam logic [1:0] OFF_CHCR = 2'd2;

  localparam logic [5:0] PCR_WADDR = 6'h3C;
  localparam logic [5:0] ICR_WADDR = 6'h3D;

  localparam int CHCR_DR = 0;
  localparam int CHCR_CO = 9;
  localparam int CHCR_LI = 10;
  localparam int CHCR_TR = 24;

  localparam int ICR_FORCE    = 15;
  localparam int ICR_EN_LSB   = 16;
  localparam int ICR_MEN      = 23;
  localparam int ICR_FLAG_LSB = 24;
  localparam int ICR_MFLAG    = 31;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/dmac_wb_regs_param_if.sv
// Pipelined Wishbone register-bus signals between the regs arbiter and the DMAC slave.
interface dmac_wb_regs_param_if;
  logic [31:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_wr;
  logic        ack;
  logic        stall;
  logic        err;
  logic [31:0] dat_rd;

  modport master (output adr, cyc, stb, we, sel, dat_wr,
                  input  ack, stall, err, dat_rd);
  modport slave  (input  adr, cyc, stb, we, sel, dat_wr,
                  output ack, stall, err, dat_rd);
endinterface

// File: rtl/dmac_wb_regs_param_ctrl.sv
// Wishbone slave handshake: one outstanding access, registered ACK/ERR.
//  state   | meaning
//  ST_IDLE | ready, an access with CYC&STB&EN is accepted
//  ST_RESP | ACK or ERR is on the bus, STALL held high for this cycle
module dmac_wb_regs_param_ctrl
  import dmac_wb_regs_param_pkg::*;
(
  input  logic CLK,
  input  logic RST_ASYNC_N,
  input  logic EN,
  input  logic cyc,
  input  logic stb,
  input  logic valid,
  output logic accept,
  output logic stall,
  output logic ack,
  output logic err
);

  ctrl_state_e state_q, state_d;

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= ST_IDLE;
    end else if (EN) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cyc && stb && EN) begin
          accept  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        stall   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else if (EN) begin
      ack <= accept && valid;
      err <= accept && !valid;
    end
  end

endmodule

// File: rtl/dmac_wb_regs_param.sv
// DMAC register slave: per-channel MADR/BCR/CHCR, common PCR/ICR, engine
// write-back of MADR/BCR and the ICR-driven level interrupt.
module dmac_wb_regs_param
  import dmac_wb_regs_param_pkg::*;
#(
  parameter int          NUM_CH   = 7,
  parameter int          ADDR_MSB = 11,
  parameter int          ADDR_LSB = 8,
  parameter logic [31:0] ADDR_VAL = 32'd0,
  parameter logic [31:0] PCR_RST  = 32'h0765_4321
) (
  input  logic                   CLK,
  input  logic                   RST_ASYNC_N,
  input  logic                   EN,
  dmac_wb_regs_param_if.slave    wb,
  output logic [32*NUM_CH-1:0]   CFG_MADR_OUT,
  output logic [32*NUM_CH-1:0]   CFG_BCR_OUT,
  output logic [NUM_CH-1:0]      CFG_CHCR_DR_OUT,
  output logic [NUM_CH-1:0]      CFG_CHCR_CO_OUT,
  output logic [NUM_CH-1:0]      CFG_CHCR_LI_OUT,
  output logic [NUM_CH-1:0]      CFG_CHCR_TR_OUT,
  output logic [31:0]            CFG_PCR_OUT,
  input  logic [NUM_CH-1:0]      HW_MADR_WR_IN,
  input  logic [NUM_CH-1:0]      HW_BCR_WR_IN,
  input  logic [32*NUM_CH-1:0]   HW_MADR_DAT_IN,
  input  logic [32*NUM_CH-1:0]   HW_BCR_DAT_IN,
  input  logic [NUM_CH-1:0]      CH_DONE_IN,
  output logic                   IRQ_OUT
);

  localparam int         AW  = ADDR_MSB - ADDR_LSB + 1;
  localparam logic [3:0] NCH = 4'(NUM_CH);

  logic [5:0]  waddr;
  logic [3:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic [31:0] mask;
  logic        addr_hit, sel_ok, reg_exists, valid, accept;
  logic        wr_en, rd_en, wr_pcr, wr_icr;
  logic        unused_adr;

  logic [31:0]       madr_q [NUM_CH];
  logic [31:0]       bcr_q  [NUM_CH];
  logic [NUM_CH-1:0] dr_q, co_q, li_q, tr_q;
  logic [NUM_CH-1:0] wr_madr, wr_bcr, wr_chcr;
  logic [31:0]       pcr_q, rd_q, rd_word, icr_word;
  logic [15:0]       icr_lo_q;
  logic [NUM_CH-1:0] icr_en_q, icr_flag_q, flag_set, flag_clr;
  logic              icr_men_q, icr_mflag, irq_q;

  assign waddr      = wb.adr[7:2];
  assign ch_idx     = waddr[5:2];
  assign reg_sel    = waddr[1:0];
  assign mask       = lane_mask(wb.sel);
  assign unused_adr = ^wb.adr;

  assign addr_hit   = (wb.adr[ADDR_MSB:ADDR_LSB] == ADDR_VAL[AW-1:0]);
  assign sel_ok     = ((wb.sel == 4'b1111) && (wb.adr[1:0] == 2'b00)) ||
                      (((wb.sel == 4'b0011) || (wb.sel == 4'b1100)) && !wb.adr[0]);
  assign reg_exists = (waddr == PCR_WADDR) || (waddr == ICR_WADDR) ||
                      ((ch_idx < NCH) && (reg_sel != 2'd3));
  assign valid      = addr_hit && sel_ok && reg_exists;

  assign wr_en  = accept && valid && wb.we;
  assign rd_en  = accept && valid && !wb.we;
  assign wr_pcr = wr_en && (waddr == PCR_WADDR);
  assign wr_icr = wr_en && (waddr == ICR_WADDR);

  dmac_wb_regs_param_ctrl u_ctrl (
    .CLK         (CLK),
    .RST_ASYNC_N (RST_ASYNC_N),
    .EN          (EN),
    .cyc         (wb.cyc),
    .stb         (wb.stb),
    .valid       (valid),
    .accept      (accept),
    .stall       (wb.stall),
    .ack         (wb.ack),
    .err         (wb.err)
  );

  always_comb begin
    wr_madr = '0;
    wr_bcr  = '0;
    wr_chcr = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wr_madr[n] = wr_en && (ch_idx == 4'(n)) && (reg_sel == OFF_MADR);
      wr_bcr[n]  = wr_en && (ch_idx == 4'(n)) && (reg_sel == OFF_BCR);
      wr_chcr[n] = wr_en && (ch_idx == 4'(n)) && (reg_sel == OFF_CHCR);
    end
  end

  // Engine write-back takes priority over a coincident bus write; the bus access is still ACKed.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      for (int n = 0; n < NUM_CH; n++) begin
        madr_q[n] <= '0;
        bcr_q[n]  <= '0;
      end
      dr_q <= '0;
      co_q <= '0;
      li_q <= '0;
      tr_q <= '0;
    end else if (EN) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (HW_MADR_WR_IN[n])  madr_q[n] <= HW_MADR_DAT_IN[32*n +: 32];
        else if (wr_madr[n])   madr_q[n] <= merge(madr_q[n], wb.dat_wr, mask);
        if (HW_BCR_WR_IN[n])   bcr_q[n]  <= HW_BCR_DAT_IN[32*n +: 32];
        else if (wr_bcr[n])    bcr_q[n]  <= merge(bcr_q[n], wb.dat_wr, mask);
        if (wr_chcr[n]) begin
          if (mask[CHCR_DR]) dr_q[n] <= wb.dat_wr[CHCR_DR];
          if (mask[CHCR_CO]) co_q[n] <= wb.dat_wr[CHCR_CO];
          if (mask[CHCR_LI]) li_q[n] <= wb.dat_wr[CHCR_LI];
        end
        if (wr_chcr[n] && mask[CHCR_TR]) tr_q[n] <= wb.dat_wr[CHCR_TR];
        else if (CH_DONE_IN[n])          tr_q[n] <= 1'b0;
      end
    end
  end

  assign flag_set  = CH_DONE_IN & icr_en_q;
  assign flag_clr  = {NUM_CH{wr_icr}} & mask[ICR_FLAG_LSB +: NUM_CH] &
                     wb.dat_wr[ICR_FLAG_LSB +: NUM_CH];
  assign icr_mflag = icr_lo_q[ICR_FORCE] | (icr_men_q & (|(icr_en_q & icr_flag_q)));

  always_comb begin
    icr_word                            = '0;
    icr_word[15:0]                      = icr_lo_q;
    icr_word[ICR_EN_LSB +: NUM_CH]      = icr_en_q;
    icr_word[ICR_MEN]                   = icr_men_q;
    icr_word[ICR_FLAG_LSB +: NUM_CH]    = icr_flag_q;
    icr_word[ICR_MFLAG]                 = icr_mflag;
  end

  always_comb begin
    rd_word = '0;
    if (waddr == PCR_WADDR) begin
      rd_word = pcr_q;
    end else if (waddr == ICR_WADDR) begin
      rd_word = icr_word;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_idx == 4'(n)) begin
          case (reg_sel)
            OFF_MADR: rd_word = madr_q[n];
            OFF_BCR:  rd_word = bcr_q[n];
            OFF_CHCR: begin
              rd_word[CHCR_DR] = dr_q[n];
              rd_word[CHCR_CO] = co_q[n];
              rd_word[CHCR_LI] = li_q[n];
              rd_word[CHCR_TR] = tr_q[n];
            end
            default: rd_word = '0;
          endcase
        end
      end
    end
  end

  // A flag set by CH_DONE_IN survives a same-cycle write-1-to-clear.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      pcr_q      <= PCR_RST;
      icr_lo_q   <= '0;
      icr_en_q   <= '0;
      icr_men_q  <= 1'b0;
      icr_flag_q <= '0;
      irq_q      <= 1'b0;
      rd_q       <= '0;
    end else if (EN) begin
      if (wr_pcr) pcr_q <= merge(pcr_q, wb.dat_wr, mask);
      if (wr_icr) begin
        icr_lo_q <= (icr_lo_q & ~mask[15:0]) | (wb.dat_wr[15:0] & mask[15:0]);
        icr_en_q <= (icr_en_q & ~mask[ICR_EN_LSB +: NUM_CH]) |
                    (wb.dat_wr[ICR_EN_LSB +: NUM_CH] & mask[ICR_EN_LSB +: NUM_CH]);
        if (mask[ICR_MEN]) icr_men_q <= wb.dat_wr[ICR_MEN];
      end
      icr_flag_q <= flag_set | (icr_flag_q & ~flag_clr);
      irq_q      <= icr_mflag;
      if (rd_en) rd_q <= rd_word & mask;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign CFG_MADR_OUT[32*g +: 32] = madr_q[g];
    assign CFG_BCR_OUT[32*g +: 32]  = bcr_q[g];
  end

  assign CFG_CHCR_DR_OUT = dr_q;
  assign CFG_CHCR_CO_OUT = co_q;
  assign CFG_CHCR_LI_OUT = li_q;
  assign CFG_CHCR_TR_OUT = tr_q;
  assign CFG_PCR_OUT     = pcr_q;
  assign IRQ_OUT         = irq_q;
  assign wb.dat_rd       = rd_q;

endmodule

// File: tb/tb_dmac_wb_regs_param.sv
// Directed bench for dmac_wb_regs_param with NUM_CH=7 and default address match.
module tb_dmac_wb_regs_param;

  logic         CLK = 1'b0;
  logic         RST_ASYNC_N;
  logic         EN;
  logic [223:0] cfg_madr, cfg_bcr, hw_madr_dat, hw_bcr_dat;
  logic [6:0]   cfg_dr, cfg_co, cfg_li, cfg_tr;
  logic [6:0]   hw_madr_wr, hw_bcr_wr, ch_done;
  logic [31:0]  cfg_pcr;
  logic         irq;

  int          total  = 0;
  int          passed = 0;
  logic        ack_r, err_r;
  logic [31:0] rd_r;

  dmac_wb_regs_param_if wb_if ();

  dmac_wb_regs_param #(.NUM_CH(7)) dut (
    .CLK             (CLK),
    .RST_ASYNC_N     (RST_ASYNC_N),
    .EN              (EN),
    .wb              (wb_if),
    .CFG_MADR_OUT    (cfg_madr),
    .CFG_BCR_OUT     (cfg_bcr),
    .CFG_CHCR_DR_OUT (cfg_dr),
    .CFG_CHCR_CO_OUT (cfg_co),
    .CFG_CHCR_LI_OUT (cfg_li),
    .CFG_CHCR_TR_OUT (cfg_tr),
    .CFG_PCR_OUT     (cfg_pcr),
    .HW_MADR_WR_IN   (hw_madr_wr),
    .HW_BCR_WR_IN    (hw_bcr_wr),
    .HW_MADR_DAT_IN  (hw_madr_dat),
    .HW_BCR_DAT_IN   (hw_bcr_dat),
    .CH_DONE_IN      (ch_done),
    .IRQ_OUT         (irq)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
    wb_if.cyc = 1'b1; wb_if.stb = 1'b1; wb_if.we = w;
    wb_if.adr = a;    wb_if.sel = s;    wb_if.dat_wr = d;
  endtask

  task automatic release_bus();
    wb_if.cyc = 1'b0; wb_if.stb = 1'b0; wb_if.we = 1'b0;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d);
    @(posedge CLK); @(negedge CLK);
    drive(w, a, s, d);
    @(posedge CLK); #1;
    release_bus();
    ack_r = wb_if.ack; err_r = wb_if.err; rd_r = wb_if.dat_rd;
  endtask

  initial begin
    release_bus();
    wb_if.adr = '0; wb_if.sel = '0; wb_if.dat_wr = '0;
    EN = 1'b1; hw_madr_wr = '0; hw_bcr_wr = '0; ch_done = '0;
    hw_madr_dat = '0; hw_bcr_dat = '0;
    RST_ASYNC_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_ASYNC_N = 1'b1; #1;

    check("rst_ack", wb_if.ack, 0);
    check("rst_err", wb_if.err, 0);
    check("rst_stall", wb_if.stall, 0);
    check("rst_irq", irq, 0);
    check("rst_pcr", cfg_pcr, 32'h0765_4321);
    check("rst_madr2", cfg_madr[95:64], 0);
    check("rst_rd", wb_if.dat_rd, 0);

    bus(1, 32'h20, 4'hF, 32'h8001_0000);
    check("madr2_wr_ack", ack_r, 1);
    check("madr2_wr_err", err_r, 0);
    check("stall_after_accept", wb_if.stall, 1);
    check("madr2_cfg", cfg_madr[95:64], 32'h8001_0000);
    bus(0, 32'h20, 4'hF, 0);
    check("madr2_rd", rd_r, 32'h8001_0000);

    bus(0, 32'hF0, 4'hF, 0);
    check("pcr_rd", rd_r, 32'h0765_4321);
    bus(0, 32'hF0, 4'b0011, 0);
    check("pcr_rd_lo", rd_r, 32'h0000_4321);
    bus(0, 32'hF2, 4'b1100, 0);
    check("pcr_rd_hi", rd_r, 32'h0765_0000);

    bus(1, 32'h70, 4'hF, 32'h1234_5678);
    check("ch7_wr_err", err_r, 1);
    check("ch7_wr_ack", ack_r, 0);
    bus(0, 32'h70, 4'hF, 0);
    check("ch7_rd_err", err_r, 1);
    check("ch7_rd_hold", rd_r, 32'h0765_0000);
    bus(1, 32'h20, 4'b0110, 32'hFFFF_FFFF);
    check("sel0110_err", err_r, 1);
    check("sel0110_nochg", cfg_madr[95:64], 32'h8001_0000);
    bus(1, 32'h0C, 4'hF, 0);
    check("off_c_err", err_r, 1);
    bus(1, 32'h120, 4'hF, 0);
    check("addr_miss_err", err_r, 1);
    check("addr_miss_nochg", cfg_madr[31:0], 0);
    bus(1, 32'h22, 4'hF, 0);
    check("misalign_err", err_r, 1);

    bus(1, 32'h04, 4'b0011, 32'hAAAA_1234);
    check("bcr0_lo", cfg_bcr[31:0], 32'h0000_1234);
    bus(1, 32'h06, 4'b1100, 32'h5678_FFFF);
    check("bcr0_hi", cfg_bcr[31:0], 32'h5678_1234);

    bus(1, 32'h38, 4'hF, 32'hFFFF_FFFF);
    check("chcr3_bits", {cfg_dr[3], cfg_co[3], cfg_li[3], cfg_tr[3]}, 4'hF);
    bus(0, 32'h38, 4'hF, 0);
    check("chcr3_rd", rd_r, 32'h0100_0601);
    @(negedge CLK); ch_done = 7'b000_1000;
    @(negedge CLK); ch_done = '0;
    bus(0, 32'h38, 4'hF, 0);
    check("chcr3_done_rd", rd_r, 32'h0000_0601);

    bus(1, 32'hF4, 4'hF, 32'h0081_0000);
    @(negedge CLK); ch_done = 7'b000_0001;
    @(negedge CLK); ch_done = '0;
    bus(0, 32'hF4, 4'hF, 0);
    check("icr_flag_rd", rd_r, 32'h8181_0000);
    check("irq_set", irq, 1);
    bus(1, 32'hF4, 4'hF, 32'h0181_0000);
    @(posedge CLK); #1;
    check("irq_clr", irq, 0);
    bus(0, 32'hF4, 4'hF, 0);
    check("icr_clr_rd", rd_r, 32'h0081_0000);
    bus(1, 32'hF4, 4'hF, 32'h00FF_8000);
    bus(0, 32'hF4, 4'hF, 0);
    check("icr_force_rd", rd_r, 32'h80FF_8000);
    check("irq_force", irq, 1);
    bus(1, 32'hF4, 4'hF, 32'hFFFF_0000);
    bus(0, 32'hF4, 4'hF, 0);
    check("icr_b31_ro", rd_r, 32'h00FF_0000);

    @(posedge CLK); @(negedge CLK);
    drive(1, 32'h14, 4'hF, 32'h10);
    hw_bcr_wr = 7'b000_0010; hw_bcr_dat[63:32] = 32'h20;
    @(posedge CLK); #1;
    release_bus(); hw_bcr_wr = '0;
    check("hw_bcr_ack", wb_if.ack, 1);
    check("hw_bcr_wins", cfg_bcr[63:32], 32'h20);

    @(posedge CLK); @(negedge CLK);
    drive(1, 32'h38, 4'hF, 32'h0100_0000);
    ch_done = 7'b000_1000;
    @(posedge CLK); #1;
    release_bus(); ch_done = '0;
    check("tr_bus_wins", cfg_tr[3], 1);
    check("dr_cleared", cfg_dr[3], 0);

    @(negedge CLK); hw_madr_wr = 7'b010_0000; hw_madr_dat[191:160] = 32'hDEAD_BEEF;
    @(negedge CLK); hw_madr_wr = '0;
    check("hw_madr5", cfg_madr[191:160], 32'hDEAD_BEEF);

    @(posedge CLK); @(negedge CLK);
    EN = 1'b0;
    drive(1, 32'hF0, 4'hF, 32'h1111_1111);
    repeat (2) @(posedge CLK);
    #1;
    check("en_low_ack", wb_if.ack, 0);
    check("en_low_err", wb_if.err, 0);
    check("en_low_pcr", cfg_pcr, 32'h0765_4321);
    @(negedge CLK); release_bus(); EN = 1'b1;

    @(posedge CLK); @(negedge CLK);
    drive(1, 32'hF0, 4'hF, 32'h1111_1111);
    #2 RST_ASYNC_N = 1'b0;
    #1;
    check("async_rst_madr", cfg_madr[95:64], 0);
    check("async_rst_tr", cfg_tr, 0);
    @(posedge CLK); #1;
    check("rst_mid_ack", wb_if.ack, 0);
    check("rst_mid_pcr", cfg_pcr, 32'h0765_4321);
    @(negedge CLK); release_bus(); RST_ASYNC_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_noack", wb_if.ack, 0);
    check("rst_mid_noerr", wb_if.err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
